// File: rtl/tbl_nr_refine.sv
// Newton-Raphson refinement of a table seed on one shared pipelined 54x54 multiplier.
// Define TBL_NR_RSQRT_EN to add reciprocal square root (in_op=1); default is reciprocal only.
module tbl_nr_refine #(
  parameter int ITERS   = 3,
  parameter int MUL_LAT = 2,
  parameter int BIAS    = 2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [67:0] in_A,
  input  logic        in_op,
  output logic        tbl_rd,
  output logic [2:0]  tbl_xtra,
  output logic [67:0] tbl_A,
  input  logic [67:0] tbl_res,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [67:0] out_res,
  output logic        out_dz
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOOK = 3'd1, S_SEED = 3'd2, S_M1 = 3'd3,
    S_M2   = 3'd4, S_M3   = 3'd5, S_NORM = 3'd6, S_OUT = 3'd7
  } state_t;

  localparam logic [7:0]         LAT_END    = 8'(MUL_LAT - 1);
  localparam logic [2:0]         IT_END     = 3'(ITERS);
  localparam logic signed [13:0] BIAS_S     = 14'(BIAS);
  localparam logic signed [13:0] TWO_BIAS_S = 14'(2 * BIAS);

  function automatic logic [53:0] nr_two_minus(input logic [53:0] p);
    logic [54:0] d;
    d = {2'b10, 53'd0} - {1'b0, p};
    return d[54] ? 54'd0 : d[53:0];
  endfunction

  function automatic logic [53:0] nr_three_minus(input logic [53:0] p);
    logic [55:0] d;
    d = {3'b011, 53'd0} - {2'b00, p};
    if (d[55]) return 54'd0;
    else if (d[54]) return {54{1'b1}};
    else return d[53:0];
  endfunction

  state_t              state_q, state_d;
  logic [67:0]         a_q, a_d;
  logic [53:0]         x_q, x_d, y_q, y_d, t_q, t_d;
  logic [2:0]          it_q, it_d;
  logic [7:0]          lat_q, lat_d;
  logic                op_q, op_d;
  logic                in_rdy_q, tbl_rd_q, out_vld_q;
  logic [2:0]          tbl_xtra_q;
  logic [67:0]         out_res_q, out_res_d;
  logic                out_dz_q, out_dz_d;
  logic [53:0]         mul_a_s, mul_b_s;
  logic [107:0]        pipe_q [MUL_LAT];
  logic [107:0]        prod_s;
  logic [11:0]         e_s, ue_in_s, exp_s;
  logic                rsqrt_s, op_in_s, odd_s, phase_end_s;
  logic signed [13:0]  e_ext_s, eo_base_s, eo_s;
  logic [53:0]         sig_s, frac_s;
  logic                unused_s;

`ifdef TBL_NR_RSQRT_EN
  assign op_in_s  = in_op;
  assign unused_s = ^tbl_res[67:54];
`else
  assign op_in_s  = 1'b0;
  assign unused_s = ^{in_op, tbl_res[67:54]};
`endif

  assign rsqrt_s     = op_q;
  assign e_s         = a_q[65:54];
  assign ue_in_s     = in_A[65:54] - 12'(BIAS);
  assign odd_s       = op_in_s & ue_in_s[0];
  assign prod_s      = pipe_q[MUL_LAT-1];
  assign phase_end_s = (lat_q == LAT_END);

  // Exponent computation, normalisation and clamping of the final estimate
  always_comb begin
    e_ext_s = $signed({2'b00, e_s});
    if (rsqrt_s) eo_base_s = BIAS_S - ((e_ext_s - BIAS_S) >>> 1);
    else         eo_base_s = TWO_BIAS_S - e_ext_s;
    if (y_q[53]) begin
      sig_s = y_q;
      eo_s  = eo_base_s;
    end else begin
      sig_s = {y_q[52:0], 1'b0};
      eo_s  = eo_base_s - 14'sd1;
    end
    if (e_s == 12'd0) begin
      exp_s = 12'hFFF; frac_s = 54'd0;
    end else if (eo_s <= 14'sd0) begin
      exp_s = 12'd0;   frac_s = 54'd0;
    end else if (eo_s > 14'sd4095) begin
      exp_s = 12'hFFF; frac_s = sig_s;
    end else begin
      exp_s = eo_s[11:0]; frac_s = sig_s;
    end
  end

  // Sequencer next state, iteration datapath and multiplier operand selection
  always_comb begin
    state_d = state_q; a_d = a_q; x_d = x_q; y_d = y_q; t_d = t_q;
    it_d = it_q; lat_d = 8'd0; op_d = op_q;
    out_res_d = out_res_q; out_dz_d = out_dz_q;
    mul_a_s = 54'd0; mul_b_s = 54'd0;
    case (state_q)
      S_IDLE: begin
        if (in_vld) begin
          state_d = S_LOOK;
          a_d     = in_A;
          op_d    = op_in_s;
          x_d     = odd_s ? {1'b0, in_A[53:1]} : in_A[53:0];
          it_d    = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOK: state_d = S_SEED;
      S_SEED: begin
        y_d = tbl_res[53:0];
        if (e_s == 12'd0) state_d = S_NORM;
        else              state_d = S_M1;
      end
      S_M1: begin
        if (phase_end_s) begin
          t_d     = rsqrt_s ? prod_s[106:53] : nr_two_minus(prod_s[106:53]);
          state_d = S_M2;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      S_M2: begin
        if (phase_end_s && rsqrt_s) begin
          t_d     = prod_s[106:53];
          state_d = S_M3;
        end else if (phase_end_s) begin
          y_d     = prod_s[106:53];
          it_d    = it_q + 3'd1;
          state_d = (it_d == IT_END) ? S_NORM : S_M1;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      S_M3: begin
        // y*(3-p) sits one bit higher, which folds in the divide by two
        if (phase_end_s) begin
          y_d     = prod_s[107:54];
          it_d    = it_q + 3'd1;
          state_d = (it_d == IT_END) ? S_NORM : S_M1;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      S_NORM: begin
        out_res_d = {2'b00, exp_s, frac_s};
        out_dz_d  = (e_s == 12'd0);
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (out_rdy) state_d = S_IDLE;
        else         state_d = S_OUT;
      end
      default: state_d = S_IDLE;
    endcase
    // Operands enter the pipe on the edge that starts a multiply phase
    case (state_d)
      S_M1: begin
        mul_a_s = rsqrt_s ? y_d : x_q;
        mul_b_s = y_d;
      end
      S_M2: begin
        mul_a_s = rsqrt_s ? x_q : y_d;
        mul_b_s = t_d;
      end
      S_M3: begin
        mul_a_s = y_d;
        mul_b_s = nr_three_minus(t_d);
      end
      default: begin
        mul_a_s = 54'd0;
        mul_b_s = 54'd0;
      end
    endcase
  end

  // Shared multiplier pipeline, flushed by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= 108'd0;
    end else begin
      pipe_q[0] <= {54'd0, mul_a_s} * {54'd0, mul_b_s};
      for (int i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // State, datapath and registered output updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE; a_q <= 68'd0; x_q <= 54'd0; y_q <= 54'd0; t_q <= 54'd0;
      it_q <= 3'd0; lat_q <= 8'd0; op_q <= 1'b0;
      in_rdy_q <= 1'b1; tbl_rd_q <= 1'b0; tbl_xtra_q <= 3'd0;
      out_vld_q <= 1'b0; out_res_q <= 68'd0; out_dz_q <= 1'b0;
    end else begin
      state_q <= state_d; a_q <= a_d; x_q <= x_d; y_q <= y_d; t_q <= t_d;
      it_q <= it_d; lat_q <= lat_d; op_q <= op_d;
      in_rdy_q   <= (state_d == S_IDLE);
      tbl_rd_q   <= (state_d == S_LOOK);
      tbl_xtra_q <= (state_d == S_LOOK) ? {2'b00, op_d} : tbl_xtra_q;
      out_vld_q  <= (state_d == S_OUT);
      out_res_q  <= out_res_d;
      out_dz_q   <= out_dz_d;
    end
  end

  assign in_rdy   = in_rdy_q;
  assign tbl_rd   = tbl_rd_q;
  assign tbl_xtra = tbl_xtra_q;
  assign tbl_A    = a_q;
  assign out_vld  = out_vld_q;
  assign out_res  = out_res_q;
  assign out_dz   = out_dz_q;

endmodule

// File: tb/tb_tbl_nr_refine.sv
// Directed self-checking bench for tbl_nr_refine with a registered seed-table model.
module tb_tbl_nr_refine;

  localparam logic [53:0] ONE     = 54'h20000000000000;
  localparam logic [53:0] X_1P5   = 54'h30000000000000;
  localparam logic [53:0] SEED_15 = 54'h15800000000000;
  localparam logic [53:0] SIG_43  = 54'h2AAAAAAAAAAAAA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld = 1'b0, in_rdy, in_op = 1'b0;
  logic [67:0] in_A = 68'd0;
  logic        tbl_rd;
  logic [2:0]  tbl_xtra;
  logic [67:0] tbl_A, tbl_res = 68'd0;
  logic        out_vld, out_rdy = 1'b1, out_dz;
  logic [67:0] out_res;
  logic [53:0] seed_v = 54'd0;
  int          n_tests = 0, n_fail = 0;

  tbl_nr_refine dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_A(in_A), .in_op(in_op),
    .tbl_rd(tbl_rd), .tbl_xtra(tbl_xtra), .tbl_A(tbl_A), .tbl_res(tbl_res),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_res(out_res), .out_dz(out_dz)
  );

  always #5 clk = ~clk;

  // Seed table: one-cycle registered read, garbage-free zero when not reading
  always @(posedge clk) tbl_res <= tbl_rd ? {14'd0, seed_v} : 68'd0;

  task automatic run_op(input logic [67:0] op, input logic [53:0] seed, output int lat,
                        output logic [67:0] res, output logic dz, output int rd_cyc,
                        output logic [67:0] rd_a, output logic [2:0] rd_x);
    int guard;
    seed_v = seed;
    @(negedge clk);
    in_A = op; in_vld = 1'b1;
    guard = 0;
    while (in_rdy !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
    lat = -1; rd_cyc = -1; rd_a = 68'd0; rd_x = 3'd0; res = 68'd0; dz = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (tbl_rd === 1'b1 && rd_cyc < 0) begin
        rd_cyc = i; rd_a = tbl_A; rd_x = tbl_xtra;
      end
      if (out_vld === 1'b1) begin
        lat = i; res = out_res; dz = out_dz;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_tests++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
    n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
    n_tests++; if (out_dz !== 1'b0) begin n_fail++; $display("FAIL reset_out_dz: got %b want 0", out_dz); end
    n_tests++; if (out_res !== 68'd0) begin n_fail++; $display("FAIL reset_out_res: got %h want 0", out_res); end
    n_tests++; if (tbl_rd !== 1'b0) begin n_fail++; $display("FAIL reset_tbl_rd: got %b want 0", tbl_rd); end
    n_tests++; if (tbl_xtra !== 3'd0) begin n_fail++; $display("FAIL reset_tbl_xtra: got %h want 0", tbl_xtra); end
    rst = 1'b0;
  endtask

  task automatic test_recip_one();
    int lat, rdc; logic [67:0] res, rda, op, exp_res; logic dz; logic [2:0] rdx;
    op = {2'b00, 12'd2047, ONE};
    exp_res = {2'b00, 12'd2047, ONE};
    run_op(op, ONE, lat, res, dz, rdc, rda, rdx);
    n_tests++; if (lat != 16) begin n_fail++; $display("FAIL one_latency: got %0d want 16", lat); end
    n_tests++; if (res !== exp_res) begin n_fail++; $display("FAIL one_result: got %h want %h", res, exp_res); end
    n_tests++; if (dz !== 1'b0) begin n_fail++; $display("FAIL one_dz: got %b want 0", dz); end
    n_tests++; if (rdc != 1) begin n_fail++; $display("FAIL one_tbl_rd_cycle: got %0d want 1", rdc); end
    n_tests++; if (rda !== op) begin n_fail++; $display("FAIL one_tbl_A: got %h want %h", rda, op); end
    n_tests++; if (rdx !== 3'd0) begin n_fail++; $display("FAIL one_tbl_xtra: got %h want 0", rdx); end
  endtask

  task automatic test_recip_exp();
    int lat, rdc; logic [67:0] res, rda, exp_res; logic dz; logic [2:0] rdx;
    exp_res = {2'b00, 12'd2046, ONE};
    run_op({2'b00, 12'd2048, ONE}, ONE, lat, res, dz, rdc, rda, rdx);
    n_tests++; if (res !== exp_res) begin n_fail++; $display("FAIL exp2048_result: got %h want %h", res, exp_res); end
  endtask

  task automatic test_recip_1p5();
    int lat, rdc; logic [67:0] res, rda; logic dz; logic [2:0] rdx; logic [53:0] diff;
    run_op({2'b00, 12'd2047, X_1P5}, SEED_15, lat, res, dz, rdc, rda, rdx);
    diff = (res[53:0] > SIG_43) ? res[53:0] - SIG_43 : SIG_43 - res[53:0];
    n_tests++; if (diff > 54'd2) begin n_fail++; $display("FAIL x1p5_sig: got %h want %h +-2", res[53:0], SIG_43); end
    n_tests++; if (res[67:54] !== 14'd2046) begin n_fail++; $display("FAIL x1p5_exp: got %0d want 2046", res[67:54]); end
    n_tests++; if (lat != 16) begin n_fail++; $display("FAIL x1p5_latency: got %0d want 16", lat); end
  endtask

  task automatic test_dz();
    int lat, rdc; logic [67:0] res, rda, exp_res; logic dz; logic [2:0] rdx;
    exp_res = {2'b00, 12'hFFF, 54'd0};
    run_op({2'b00, 12'd0, ONE}, ONE, lat, res, dz, rdc, rda, rdx);
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL dz_latency: got %0d want 4", lat); end
    n_tests++; if (dz !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", dz); end
    n_tests++; if (res !== exp_res) begin n_fail++; $display("FAIL dz_result: got %h want %h", res, exp_res); end
  endtask

  task automatic test_exp_clamp();
    int lat, rdc; logic [67:0] res, rda, exp_res; logic dz; logic [2:0] rdx;
    run_op({2'b00, 12'd4094, ONE}, ONE, lat, res, dz, rdc, rda, rdx);
    n_tests++; if (res !== 68'd0) begin n_fail++; $display("FAIL clamp_zero: got %h want 0", res); end
    n_tests++; if (dz !== 1'b0) begin n_fail++; $display("FAIL clamp_zero_dz: got %b want 0", dz); end
    exp_res = {2'b00, 12'd1, ONE};
    run_op({2'b00, 12'd4093, ONE}, ONE, lat, res, dz, rdc, rda, rdx);
    n_tests++; if (res !== exp_res) begin n_fail++; $display("FAIL clamp_min_exp: got %h want %h", res, exp_res); end
  endtask

  task automatic test_backpressure();
    int lat; logic [67:0] exp_a, exp_b;
    exp_a = {2'b00, 12'd2047, ONE};
    exp_b = {2'b00, 12'd2046, ONE};
    seed_v = ONE; out_rdy = 1'b0;
    @(negedge clk);
    in_A = {2'b00, 12'd2047, ONE}; in_vld = 1'b1;
    @(posedge clk); #1;
    in_A = {2'b00, 12'd2048, ONE};
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_vld === 1'b1) begin lat = i; break; end
    end
    n_tests++; if (lat != 16) begin n_fail++; $display("FAIL bp_first_latency: got %0d want 16", lat); end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (out_res !== exp_a || in_rdy !== 1'b0 || out_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got res=%h rdy=%b vld=%b want res=%h rdy=0 vld=1", i, out_res, in_rdy, out_vld, exp_a);
      end
      @(negedge clk);
    end
    out_rdy = 1'b1;
    @(negedge clk);
    n_tests++; if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin n_fail++; $display("FAIL bp_release: got rdy=%b vld=%b want 1 0", in_rdy, out_vld); end
    @(posedge clk); #1;
    in_vld = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_vld === 1'b1) begin lat = i; break; end
    end
    n_tests++; if (lat != 16) begin n_fail++; $display("FAIL bp_second_latency: got %0d want 16", lat); end
    n_tests++; if (out_res !== exp_b) begin n_fail++; $display("FAIL bp_second_result: got %h want %h", out_res, exp_b); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, rdc; logic [67:0] res, rda; logic dz; logic [2:0] rdx; logic [53:0] diff;
    seed_v = ONE;
    @(negedge clk);
    in_A = {2'b00, 12'd2047, ONE}; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got in_rdy=%b want 0", in_rdy); end
    rst = 1'b1;
    #1;
    n_tests++; if (out_vld !== 1'b0 || tbl_rd !== 1'b0) begin n_fail++; $display("FAIL rmid_outputs: got vld=%b rd=%b want 0 0", out_vld, tbl_rd); end
    n_tests++; if (in_rdy !== 1'b1 || out_res !== 68'd0) begin n_fail++; $display("FAIL rmid_state: got rdy=%b res=%h want 1 0", in_rdy, out_res); end
    @(negedge clk);
    rst = 1'b0;
    run_op({2'b00, 12'd2047, X_1P5}, SEED_15, lat, res, dz, rdc, rda, rdx);
    diff = (res[53:0] > SIG_43) ? res[53:0] - SIG_43 : SIG_43 - res[53:0];
    n_tests++; if (lat != 16) begin n_fail++; $display("FAIL rmid_latency: got %0d want 16", lat); end
    n_tests++; if (diff > 54'd2 || res[67:54] !== 14'd2046) begin n_fail++; $display("FAIL rmid_result: got %h want exp 2046 sig %h +-2", res, SIG_43); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_recip_one();
    test_recip_exp();
    test_recip_1p5();
    test_dz();
    test_exp_clamp();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
